alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised, handshaked successor to the single-cycle 16-bit datapath ALU. Same op set and operand-inversion and sign semantics, generalised to WIDTH bits. The result is registered behind a valid/ready interface. Op 4'hC becomes an iterative shift-add multiplier that stalls the issue side while it runs. Sits in the EX stage of the pipeline; the hazard unit consumes in_ready and busy.

Parameters:
WIDTH, 16, operand/result width; power of two, >= 8
SHW, $clog2(WIDTH), localparam: shift-amount width taken from b[SHW-1:0]

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation presented
in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready at posedge
op  in  4  operation code (alu_pkg)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry in (ADD)
inv_a  in  1  use ~a
inv_b  in  1  use ~b
sign  in  1  signed interpretation (ADD ofl, SLT/SLE, MUL ofl)
out_valid  out  1  result registered and held
out_ready  in  1  consumer takes result at posedge when out_valid && out_ready
out  out  WIDTH  result
ofl  out  1  overflow flag
z  out  1  out == 0
busy  out  1  multiplier running

Behaviour:
- Reset (async assert, sync deassert handled upstream): out_valid=0, out=0, ofl=0, z=0, busy=0, FSM=IDLE. Mid-multiply reset aborts; partial product discarded.
- Operands: A = inv_a ? ~a : a; B = inv_b ? ~b : b. Applied before every op.
- in_ready = !busy && (!out_valid || out_ready). Single-cycle ops: accepted at edge N; out/ofl/z/out_valid=1 valid after edge N (latency 1). Output held stable while out_valid && !out_ready.
- Ops:
  - 0 ROL A by B[SHW-1:0]
  - 1 SLL
  - 2 ROR
  - 3 SRL
  - 4 ADD A+B+cin
  - 5 OR
  - 6 XOR
  - 7 AND
  - 8 bit-reverse A
  - 9 SEQ (A==B)
  - A SLT (A<B)
  - B SLE (A<=B)
  - C MUL
  - D pass B
  - E (A << WIDTH/2) | B[WIDTH/2-1:0]
  - F pass A
- Compares are signed when sign=1, unsigned otherwise. Compare results are zero-extended 1/0.
- ADD ofl: sign=0 gives carry out of bit WIDTH-1. sign=1 gives signed overflow (operand signs equal, result sign differs). All other single-cycle ops drive ofl=0.
- z = (out==0) for every op.
- MUL FSM:
  - IDLE: on accept of op C, load multiplicand, multiplier and 2*WIDTH accumulator; busy=1; enter RUN.
  - RUN: one multiplier bit per cycle for WIDTH cycles (counter 0..WIDTH-1). Signed mode runs on magnitudes and negates the result at the end.
  - DONE: write out = low WIDTH bits, out_valid=1, busy=0; return to IDLE. Total latency WIDTH+1 edges from accept.
  - MUL ofl: sign=0 sets ofl when high half != 0. sign=1 sets ofl when the high half is not the sign-extension of the low result bit WIDTH-1.
- Issue during MUL: in_ready=0 throughout RUN/DONE. A pending previous result may still be drained (out_ready) while RUN proceeds. DONE waits (stays in DONE, busy=1) while out_valid && !out_ready.
- Simultaneous drain and accept on the same edge is legal and yields back-to-back results with no bubble.

Optional Feature:
ALU_MUL_EN
- Defined: op C is the iterative multiplier above.
- Undefined: op C is single-cycle SCO. out = zero-extended carry-out of A+B+cin, ofl=0. Multiplier FSM, counter and accumulator are not built; busy tied 0.

Decomposition:
- alu_pkg: op-code localparams (OP_ROL..OP_PASSA, OP_MUL = 4'hC) and FSM state encoding (IDLE/RUN/DONE).
- One sub-module: alu_mul_seq, holding the counter, accumulator, sign fix-up and done pulse. Instantiated only under ALU_MUL_EN.
- Combinational op mux and output register live in alu_mc.

Test Plan:
- ADD, WIDTH=16, a=7FFF b=0001 cin=0 sign=1 -> after 1 edge out=8000 ofl=1 z=0 out_valid=1.
- ADD a=FFFF b=0001 sign=0 -> out=0000 z=1 ofl=1. Same with inv_b=1, b=FFFE -> identical result.
- ROL a=8001 b=0004 -> 0018. ROR a=8001 b=0004 -> 1800. SLT a=FFFF b=0001 -> sign=1 gives 0001, sign=0 gives 0000.
- MUL (ALU_MUL_EN) a=0012 b=0034 sign=0 -> in_ready=0 and busy=1 for 16 cycles, out=03A8 ofl=0 at edge 17. a=FFFF b=0003 -> sign=1 gives FFFD ofl=0; sign=0 gives FFFD ofl=1.
- Backpressure: out_ready=0 with out_valid=1 -> out held, in_ready=0, new op not accepted. Raise out_ready with in_valid=1 -> drain and accept on the same edge.
- Reset asserted 5 cycles into a MUL -> out_valid=0, busy=0 immediately. After release, in_ready=1 and a following ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes and multiplier FSM encoding for the alu_mc EX-stage ALU.
// The multiplier build is selected by the ALU_MUL_EN macro (see alu_mc.sv).
package alu_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_ROL   = 4'h0;
    localparam op_t OP_SLL   = 4'h1;
    localparam op_t OP_ROR   = 4'h2;
    localparam op_t OP_SRL   = 4'h3;
    localparam op_t OP_ADD   = 4'h4;
    localparam op_t OP_OR    = 4'h5;
    localparam op_t OP_XOR   = 4'h6;
    localparam op_t OP_AND   = 4'h7;
    localparam op_t OP_REV   = 4'h8;
    localparam op_t OP_SEQ   = 4'h9;
    localparam op_t OP_SLT   = 4'hA;
    localparam op_t OP_SLE   = 4'hB;
    localparam op_t OP_MUL   = 4'hC;
    localparam op_t OP_PASSB = 4'hD;
    localparam op_t OP_CAT   = 4'hE;
    localparam op_t OP_PASSA = 4'hF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mc_if.sv
// Issue/result handshake bundle between the EX-stage issue logic and alu_mc.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             inv_a;
    logic             inv_b;
    logic             sign;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             ofl;
    logic             z;
    logic             busy;

    modport master (
        output in_valid, op, a, b, cin, inv_a, inv_b, sign, out_ready,
        input  in_ready, out_valid, out, ofl, z, busy
    );

    modport slave (
        input  in_valid, op, a, b, cin, inv_a, inv_b, sign, out_ready,
        output in_ready, out_valid, out, ofl, z, busy
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, sign handled on magnitudes.
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_sign,
    input  logic             i_hold,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ofl
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic [1:0]         r_state;
    logic [SHW-1:0]     r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic               r_sign;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_prod;

    assign w_mag_a = (i_sign && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mag_b = (i_sign && i_b[WIDTH-1]) ? -i_b : i_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_sign   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_neg    <= i_sign & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        r_sign   <= i_sign;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == SHW'(WIDTH - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Result stays parked here until the output register is free.
                    if (!i_hold) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_prod   = r_neg ? -r_acc : r_acc;
    assign o_result = w_prod[WIDTH-1:0];
    assign o_ofl    = r_sign ? (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}})
                             : (w_prod[2*WIDTH-1:WIDTH] != '0);
    assign o_busy   = (r_state != ST_IDLE);
    assign o_done   = (r_state == ST_DONE) && !i_hold;

endmodule

// File: rtl/alu_mc.sv
// Handshaked WIDTH-bit EX-stage ALU with registered result.
// Define ALU_MUL_EN for the iterative multiplier on op C; otherwise op C is carry-out (SCO).
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic   clk,
    input logic   rst_n,
    alu_mc_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_out;
    logic             r_ofl;
    logic             r_z;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [SHW-1:0]   w_sh;
    logic [SHW:0]     w_rsh;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_rev;
    logic             w_lt;
    logic             w_eq;
    logic [WIDTH-1:0] w_res;
    logic             w_ofl;
    logic             w_accept;
    logic             w_start;
    logic             w_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_res;
    logic             w_mul_ofl;

    assign w_a   = bus.inv_a ? ~bus.a : bus.a;
    assign w_b   = bus.inv_b ? ~bus.b : bus.b;
    assign w_sh  = w_b[SHW-1:0];
    // Complementary shift for rotates; a zero amount shifts the wrap term fully out.
    assign w_rsh = (SHW + 1)'(WIDTH) - {1'b0, w_sh};
    assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, bus.cin};
    assign w_eq  = (w_a == w_b);
    assign w_lt  = bus.sign ? ($signed(w_a) < $signed(w_b)) : (w_a < w_b);

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_rev[i] = w_a[WIDTH-1-i];
        end
    end

    always_comb begin
        w_res = '0;
        w_ofl = 1'b0;
        case (bus.op)
            OP_ROL:   w_res = (w_a << w_sh) | (w_a >> w_rsh);
            OP_SLL:   w_res = w_a << w_sh;
            OP_ROR:   w_res = (w_a >> w_sh) | (w_a << w_rsh);
            OP_SRL:   w_res = w_a >> w_sh;
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_ofl = bus.sign ? ((w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                                    (w_sum[WIDTH-1] != w_a[WIDTH-1]))
                                 : w_sum[WIDTH];
            end
            OP_OR:    w_res = w_a | w_b;
            OP_XOR:   w_res = w_a ^ w_b;
            OP_AND:   w_res = w_a & w_b;
            OP_REV:   w_res = w_rev;
            OP_SEQ:   w_res = {{(WIDTH-1){1'b0}}, w_eq};
            OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, w_lt};
            OP_SLE:   w_res = {{(WIDTH-1){1'b0}}, w_lt | w_eq};
`ifdef ALU_MUL_EN
            OP_MUL:   w_res = '0;
`else
            OP_MUL:   w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
`endif
            OP_PASSB: w_res = w_b;
            OP_CAT:   w_res = (w_a << (WIDTH/2)) | {{(WIDTH/2){1'b0}}, w_b[WIDTH/2-1:0]};
            OP_PASSA: w_res = w_a;
            default:  w_res = '0;
        endcase
    end

    assign bus.in_ready = !w_busy && (!r_out_valid || bus.out_ready);
    assign w_accept     = bus.in_valid && bus.in_ready;

`ifdef ALU_MUL_EN
    assign w_start = w_accept && (bus.op == OP_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_sign   (bus.sign),
        .i_hold   (r_out_valid && !bus.out_ready),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_busy   (w_busy),
        .o_done   (w_mul_done),
        .o_result (w_mul_res),
        .o_ofl    (w_mul_ofl)
    );
`else
    assign w_start    = 1'b0;
    assign w_busy     = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_mul_res  = '0;
    assign w_mul_ofl  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_ofl       <= 1'b0;
            r_z         <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_mul_done) begin
            r_out       <= w_mul_res;
            r_ofl       <= w_mul_ofl;
            r_z         <= (w_mul_res == '0);
            r_out_valid <= 1'b1;
        end else if (w_accept && !w_start) begin
            r_out       <= w_res;
            r_ofl       <= w_ofl;
            r_z         <= (w_res == '0);
            r_out_valid <= 1'b1;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out       = r_out;
    assign bus.ofl       = r_ofl;
    assign bus.z         = r_z;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = w_busy;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: arithmetic reference model plus literal vectors.
// Exercises the multiplier path when ALU_MUL_EN is defined, the SCO path otherwise.
module tb_alu_mc;
    import alu_pkg::*;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_mc_if #(.WIDTH(16)) bus ();

    alu_mc #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: result of one operation straight from the arithmetic definition.
    function automatic logic [16:0] calc(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin,
                                         input logic ia, input logic ib, input logic sg);
        logic [15:0] ta, tb, r;
        logic        o;
        int          x, y, sh, s;
        ta = ia ? ~a : a;
        tb = ib ? ~b : b;
        x  = int'(ta);
        y  = int'(tb);
        sh = int'(tb[3:0]);
        r  = '0;
        o  = 1'b0;
        case (op)
            4'h0: r = 16'((x << sh) | (x >> (16 - sh)));
            4'h1: r = 16'(x << sh);
            4'h2: r = 16'((x >> sh) | (x << (16 - sh)));
            4'h3: r = 16'(x >> sh);
            4'h4: begin
                s = x + y + int'(cin);
                r = 16'(s);
                if (sg) begin
                    s = int'($signed(ta)) + int'($signed(tb)) + int'(cin);
                    o = (s > 32767) || (s < -32768);
                end else begin
                    o = (s > 65535);
                end
            end
            4'h5: r = ta | tb;
            4'h6: r = ta ^ tb;
            4'h7: r = ta & tb;
            4'h8: for (int i = 0; i < 16; i++) r[i] = ta[15-i];
            4'h9: r = (x == y) ? 16'd1 : 16'd0;
            4'hA: r = (sg ? (int'($signed(ta)) < int'($signed(tb))) : (x < y)) ? 16'd1 : 16'd0;
            4'hB: r = (sg ? (int'($signed(ta)) <= int'($signed(tb))) : (x <= y)) ? 16'd1 : 16'd0;
            4'hC: begin
`ifdef ALU_MUL_EN
                longint pa, pb, p;
                pa = sg ? longint'($signed(ta)) : longint'(ta);
                pb = sg ? longint'($signed(tb)) : longint'(tb);
                p  = pa * pb;
                r  = 16'(p);
                o  = sg ? ((p > 32767) || (p < -32768)) : (p > 65535);
`else
                r = 16'((x + y + int'(cin)) >> 16);
`endif
            end
            4'hD: r = tb;
            4'hE: r = 16'((x << 8) | (y & 255));
            default: r = ta;
        endcase
        return {o, r};
    endfunction

    // Transaction-level model of the output register and multiplier occupancy.
    logic        m_valid;
    logic [15:0] m_out, p_out;
    logic        m_ofl, p_ofl;
    int          m_busy;
    logic        exp_rdy;
    logic [16:0] cur;

    always_comb exp_rdy = (m_busy == 0) && (!m_valid || bus.out_ready);
    always_comb cur = calc(bus.op, bus.a, bus.b, bus.cin, bus.inv_a, bus.inv_b, bus.sign);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_busy  <= 0;
            m_out   <= '0;
            m_ofl   <= 1'b0;
            p_out   <= '0;
            p_ofl   <= 1'b0;
        end else if (m_busy > 1) begin
            m_busy <= m_busy - 1;
            if (m_valid && bus.out_ready) m_valid <= 1'b0;
        end else if (m_busy == 1) begin
            if (!m_valid || bus.out_ready) begin
                m_valid <= 1'b1;
                m_out   <= p_out;
                m_ofl   <= p_ofl;
                m_busy  <= 0;
            end
        end else if (bus.in_valid && exp_rdy) begin
            if (MUL_EN && bus.op == OP_MUL) begin
                m_busy  <= 17;
                p_out   <= cur[15:0];
                p_ofl   <= cur[16];
                m_valid <= 1'b0;
            end else begin
                m_valid <= 1'b1;
                m_out   <= cur[15:0];
                m_ofl   <= cur[16];
            end
        end else if (m_valid && bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
            chk("busy", {31'd0, bus.busy}, {31'd0, (m_busy != 0)});
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
            if (m_valid) begin
                chk("out", {16'd0, bus.out}, {16'd0, m_out});
                chk("ofl", {31'd0, bus.ofl}, {31'd0, m_ofl});
                chk("z", {31'd0, bus.z}, {31'd0, (m_out == 16'd0)});
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic ia, input logic ib, input logic sg);
        logic got;
        bus.op = op; bus.a = a; bus.b = b; bus.cin = cin;
        bus.inv_a = ia; bus.inv_b = ib; bus.sign = sg;
        bus.in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = bus.in_ready;
        end
        if (!got) chk("issue_ready", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic lit(input string name, input logic [15:0] eo, input logic eofl,
                       input logic ez);
        chk({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({name, "_out"}, {16'd0, bus.out}, {16'd0, eo});
        chk({name, "_ofl"}, {31'd0, bus.ofl}, {31'd0, eofl});
        chk({name, "_z"}, {31'd0, bus.z}, {31'd0, ez});
    endtask

`ifdef ALU_MUL_EN
    task automatic mul_run(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic sg, input logic [15:0] eo, input logic eofl);
        int n;
        issue(OP_MUL, a, b, 1'b0, 1'b0, 1'b0, sg);
        chk({name, "_rdy_low"}, {31'd0, bus.in_ready}, 32'd0);
        chk({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
        n = 0;
        for (int i = 0; i < 40 && !bus.out_valid; i++) begin
            @(posedge clk);
            #1 n++;
        end
        chk({name, "_latency"}, n, 32'd17);
        lit(name, eo, eofl, eo == 16'd0);
    endtask
`endif

    logic [3:0]  t_op [10] = '{OP_SLL, OP_SRL, OP_OR, OP_XOR, OP_AND, OP_SEQ, OP_SLE,
                               OP_PASSB, OP_PASSA, OP_SLE};
    logic [15:0] t_a  [10] = '{16'h00F3, 16'hF300, 16'h0F0F, 16'hFF00, 16'h3C3C, 16'h1234,
                               16'h8000, 16'h1111, 16'hBEEF, 16'h0005};
    logic [15:0] t_b  [10] = '{16'h0005, 16'h0007, 16'hF000, 16'h0FF0, 16'h0FF0, 16'h1234,
                               16'h7FFF, 16'h5A5A, 16'h0000, 16'h0005};
    logic        t_s  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        bus.inv_a = 1'b0; bus.inv_b = 1'b0; bus.sign = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out", {16'd0, bus.out}, 32'd0);
        chk("rst_ofl", {31'd0, bus.ofl}, 32'd0);
        chk("rst_z", {31'd0, bus.z}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        lit("add_sofl", 16'h8000, 1'b1, 1'b0);
        issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("add_carry", 16'h0000, 1'b1, 1'b1);
        issue(OP_ADD, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        lit("add_invb", 16'h0000, 1'b1, 1'b1);
        issue(OP_ROL, 16'h8001, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("rol", 16'h0018, 1'b0, 1'b0);
        issue(OP_ROR, 16'h8001, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("ror", 16'h1800, 1'b0, 1'b0);
        issue(OP_SLT, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        lit("slt_s", 16'h0001, 1'b0, 1'b0);
        issue(OP_SLT, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("slt_u", 16'h0000, 1'b0, 1'b1);
        issue(OP_REV, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("rev", 16'h8000, 1'b0, 1'b0);
        issue(OP_CAT, 16'h12AB, 16'h34CD, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("cat", 16'hABCD, 1'b0, 1'b0);
        issue(OP_PASSA, 16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        lit("inva", 16'hFF00, 1'b0, 1'b0);
        issue(OP_ROL, 16'hA5C3, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("rol0", 16'hA5C3, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            issue(t_op[i], t_a[i], t_b[i], 1'b0, 1'b0, 1'b0, t_s[i]);
        end

`ifdef ALU_MUL_EN
        mul_run("mul_u", 16'h0012, 16'h0034, 1'b0, 16'h03A8, 1'b0);
        mul_run("mul_s", 16'hFFFF, 16'h0003, 1'b1, 16'hFFFD, 1'b0);
        mul_run("mul_uofl", 16'hFFFF, 16'h0003, 1'b0, 16'hFFFD, 1'b1);
        mul_run("mul_neg", 16'hFFF9, 16'h0006, 1'b1, 16'hFFD6, 1'b0);
`else
        issue(OP_MUL, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("sco_c", 16'h0001, 1'b0, 1'b0);
        issue(OP_MUL, 16'h0012, 16'h0034, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("sco_nc", 16'h0000, 1'b0, 1'b1);
`endif

        // Backpressure: held result, then drain and accept on one edge.
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        issue(OP_ADD, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.op = OP_ADD; bus.a = 16'h0005; bus.b = 16'h0006;
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        lit("bp_hold", 16'h0003, 1'b0, 1'b0);
        chk("bp_rdy_low", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lit("bp_b2b", 16'h000B, 1'b0, 1'b0);

        // Reset during an operation in flight.
`ifdef ALU_MUL_EN
        bus.op = OP_MUL; bus.a = 16'h0012; bus.b = 16'h0034; bus.sign = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy_pre", {31'd0, bus.busy}, 32'd1);
`endif
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rdy", {31'd0, bus.in_ready}, 32'd1);
        issue(OP_ADD, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("post_rst_add", 16'h0007, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
